uart_tx_scheduler: RTL and testbench

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_tx_scheduler.sv | 131 +++++++++++++
 tb/tb_uart_tx_scheduler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter feeding one UART serializer: accepts one byte per frame from 3 requesters.
// Accept in IDLE (comb req_ready), tx_start next cycle; requesters are held off until WAIT/GAP finish.
module uart_tx_scheduler #(
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req_valid,
    input  logic [23:0] req_data,
    output logic [2:0]  req_ready,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        busy,
    output logic [1:0]  grant_id,
    output logic        timeout_err,
    input  logic        err_clr
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;

    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  GAP_LAST = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

    state_t      r_state;
    logic [1:0]  r_last_grant;
    logic [15:0] r_wait_cnt;
    logic [7:0]  r_gap_cnt;
    logic        r_tx_start;
    logic [7:0]  r_tx_data;
    logic [1:0]  r_grant_id;
    logic        r_busy;
    logic        r_timeout_err;

    logic [1:0]  w_c0;
    logic [1:0]  w_c1;
    logic [1:0]  w_c2;
    logic [1:0]  w_grant_idx;
    logic        w_accept;

    function automatic logic [1:0] f_next(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // Search order starts just after the last winner and wraps over indices 0..2.
    always_comb begin
        w_c0 = f_next(r_last_grant);
        w_c1 = f_next(w_c0);
        w_c2 = f_next(w_c1);
        if (req_valid[w_c0])
            w_grant_idx = w_c0;
        else if (req_valid[w_c1])
            w_grant_idx = w_c1;
        else
            w_grant_idx = w_c2;
    end

    // rst gates the strobe so nothing looks accepted while reset is held.
    assign w_accept  = (r_state == S_IDLE) && !rst && (|req_valid);
    assign req_ready = w_accept ? (3'b001 << w_grant_idx) : 3'b000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_last_grant  <= 2'd2;
            r_wait_cnt    <= 16'd0;
            r_gap_cnt     <= 8'd0;
            r_tx_start    <= 1'b0;
            r_tx_data     <= 8'h00;
            r_grant_id    <= 2'd0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            if (err_clr)
                r_timeout_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state      <= S_START;
                        r_tx_start   <= 1'b1;
                        r_tx_data    <= req_data[{w_grant_idx, 3'b000} +: 8];
                        r_grant_id   <= w_grant_idx;
                        r_last_grant <= w_grant_idx;
                        r_busy       <= 1'b1;
                    end
                end
                S_START: begin
                    r_state    <= S_WAIT;
                    r_wait_cnt <= 16'd0;
                end
                S_WAIT: begin
                    if (tx_done || (r_wait_cnt == TO_LAST)) begin
                        // A late tx_done on the last allowed cycle still counts as success.
                        if (!tx_done)
                            r_timeout_err <= 1'b1;
                        if (GAP_CYCLES == 0) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state   <= S_GAP;
                            r_gap_cnt <= 8'd0;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_start    = r_tx_start;
    assign tx_data     = r_tx_data;
    assign grant_id    = r_grant_id;
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: default build (gap 2, timeout 64) plus a zero-gap build.
module tb_uart_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [23:0] req_data;
    logic [2:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        busy;
    logic [1:0]  grant_id;
    logic        timeout_err;
    logic        err_clr;

    logic [2:0]  b_req_valid;
    logic [23:0] b_req_data;
    logic [2:0]  b_req_ready;
    logic        b_tx_start;
    logic [7:0]  b_tx_data;
    logic        b_tx_done;
    logic        b_busy;
    logic [1:0]  b_grant_id;
    logic        b_timeout_err;
    logic        b_err_clr;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_scheduler #(.GAP_CYCLES(2), .TIMEOUT_CYCLES(64)) dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
        .tx_done(tx_done), .busy(busy), .grant_id(grant_id),
        .timeout_err(timeout_err), .err_clr(err_clr)
    );

    uart_tx_scheduler #(.GAP_CYCLES(0), .TIMEOUT_CYCLES(64)) dut_b (
        .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_data(b_req_data),
        .req_ready(b_req_ready), .tx_start(b_tx_start), .tx_data(b_tx_data),
        .tx_done(b_tx_done), .busy(b_busy), .grant_id(b_grant_id),
        .timeout_err(b_timeout_err), .err_clr(b_err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int s;
        int last_s;

        rst = 1'b1; req_valid = 3'b111; req_data = 24'h0; tx_done = 1'b0; err_clr = 1'b0;
        b_req_valid = 3'b111; b_req_data = 24'h0; b_tx_done = 1'b0; b_err_clr = 1'b0;
        step(2);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_tx_start", 32'(tx_start), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_grant_id", 32'(grant_id), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_timeout_err", 32'(timeout_err), 32'h0);
        chk("rst_b_req_ready", 32'(b_req_ready), 32'h0);
        req_valid = 3'b000; b_req_valid = 3'b000; rst = 1'b0;
        step(1);

        // Single request from requester 1
        req_valid = 3'b010; req_data = 24'h33A511; #1;
        chk("single_ready", 32'(req_ready), 32'b010);
        step(1);
        req_valid = 3'b000; req_data = 24'hFFFFFF; #1;
        chk("single_start", 32'(tx_start), 32'h1);
        chk("single_data", 32'(tx_data), 32'hA5);
        chk("single_grant", 32'(grant_id), 32'h1);
        chk("single_busy", 32'(busy), 32'h1);
        chk("single_ready_off", 32'(req_ready), 32'h0);
        step(1);
        chk("single_start_off", 32'(tx_start), 32'h0);
        step(3);
        tx_done = 1'b1; step(1); tx_done = 1'b0;
        chk("single_gap1_busy", 32'(busy), 32'h1);
        step(1);
        chk("single_gap2_busy", 32'(busy), 32'h1);
        step(1);
        chk("single_idle_busy", 32'(busy), 32'h0);
        chk("single_hold_data", 32'(tx_data), 32'hA5);
        chk("single_hold_grant", 32'(grant_id), 32'h1);

        // Timeout with err_clr colliding on the setting edge
        req_valid = 3'b001; req_data = 24'h00003C; #1;
        chk("to_ready", 32'(req_ready), 32'b001);
        step(1);
        req_valid = 3'b000;
        chk("to_data", 32'(tx_data), 32'h3C);
        step(1);
        step(63);
        chk("to_not_yet", 32'(timeout_err), 32'h0);
        chk("to_wait_busy", 32'(busy), 32'h1);
        err_clr = 1'b1; step(1); err_clr = 1'b0;
        chk("to_set_wins", 32'(timeout_err), 32'h1);
        chk("to_gap1_busy", 32'(busy), 32'h1);
        step(1);
        chk("to_gap2_busy", 32'(busy), 32'h1);
        step(1);
        chk("to_idle_busy", 32'(busy), 32'h0);
        chk("to_sticky", 32'(timeout_err), 32'h1);
        err_clr = 1'b1; step(1); err_clr = 1'b0;
        chk("to_cleared", 32'(timeout_err), 32'h0);

        // tx_done on final timeout cycle, tx_done inside GAP, dropped request
        req_valid = 3'b100; req_data = 24'h7E0000; #1;
        chk("bd_ready", 32'(req_ready), 32'b100);
        step(1);
        req_valid = 3'b000;
        step(1);
        req_valid = 3'b001; #1;
        chk("bd_ready_not_idle", 32'(req_ready), 32'h0);
        step(1);
        req_valid = 3'b000;
        step(62);
        tx_done = 1'b1; step(1); tx_done = 1'b0;
        chk("bd_no_err", 32'(timeout_err), 32'h0);
        chk("bd_gap1_busy", 32'(busy), 32'h1);
        tx_done = 1'b1; step(1); tx_done = 1'b0;
        chk("bd_gap2_busy", 32'(busy), 32'h1);
        step(1);
        chk("bd_gap_len", 32'(busy), 32'h0);
        step(3);
        chk("bd_drop_busy", 32'(busy), 32'h0);
        chk("bd_drop_start", 32'(tx_start), 32'h0);
        chk("bd_grant", 32'(grant_id), 32'h2);
        chk("bd_data", 32'(tx_data), 32'h7E);

        // Reset three cycles after tx_start
        req_valid = 3'b100; req_data = 24'hC70000; #1;
        chk("rw_ready", 32'(req_ready), 32'b100);
        step(1);
        req_valid = 3'b000;
        chk("rw_start", 32'(tx_start), 32'h1);
        step(3);
        chk("rw_pre_busy", 32'(busy), 32'h1);
        req_valid = 3'b111; rst = 1'b1; #1;
        chk("rw_busy", 32'(busy), 32'h0);
        chk("rw_data", 32'(tx_data), 32'h0);
        chk("rw_grant", 32'(grant_id), 32'h0);
        chk("rw_start_off", 32'(tx_start), 32'h0);
        chk("rw_ready_off", 32'(req_ready), 32'h0);
        step(2);
        req_valid = 3'b000; rst = 1'b0;
        step(3);
        chk("rw_no_pulse", 32'(tx_start), 32'h0);
        chk("rw_idle", 32'(busy), 32'h0);

        // Fairness with all requesters pending, tx_done 12 cycles after each tx_start
        req_valid = 3'b111; req_data = 24'hC2B1A0; #1;
        chk("fair_first_ready", 32'(req_ready), 32'b001);
        last_s = 0;
        for (int g = 0; g < 6; g++) begin
            w = 0;
            while (tx_start !== 1'b1 && w < 40) begin
                step(1);
                w++;
            end
            chk("fair_start_seen", 32'(tx_start), 32'h1);
            s = cyc;
            chk("fair_grant", 32'(grant_id), 32'(g % 3));
            chk("fair_data", 32'(tx_data), 32'hA0 + 32'h11 * 32'(g % 3));
            if (g > 0)
                chk("fair_sep", 32'((s - last_s) >= 15), 32'h1);
            last_s = s;
            if (g == 5)
                req_valid = 3'b000;
            step(12);
            tx_done = 1'b1; step(1); tx_done = 1'b0;
        end

        // Zero-gap build: back-to-back acceptance right after tx_done
        b_req_valid = 3'b001; b_req_data = 24'h00005A; #1;
        chk("z_ready", 32'(b_req_ready), 32'b001);
        step(1);
        b_req_valid = 3'b000;
        chk("z_start", 32'(b_tx_start), 32'h1);
        chk("z_data", 32'(b_tx_data), 32'h5A);
        step(4);
        b_req_valid = 3'b010; b_req_data = 24'h00E100; b_tx_done = 1'b1; #1;
        chk("z_ready_m", 32'(b_req_ready), 32'h0);
        step(1);
        b_tx_done = 1'b0; #1;
        chk("z_ready_m1", 32'(b_req_ready), 32'b010);
        chk("z_busy_m1", 32'(b_busy), 32'h0);
        step(1);
        chk("z_start_m2", 32'(b_tx_start), 32'h1);
        chk("z_grant_m2", 32'(b_grant_id), 32'h1);
        chk("z_data_m2", 32'(b_tx_data), 32'hE1);
        chk("z_no_err", 32'(b_timeout_err), 32'h0);
        b_req_valid = 3'b000;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
